// File: rtl/mux_arb_nx1_pkg.sv
// mux_arb_nx1_pkg: shared mode encodings and index-width helper for mux_arb_nx1.
package mux_arb_nx1_pkg;
    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Index width is max(1, clog2(n)) so a single channel still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mux_arb_nx1_rr_arbiter.sv
// rr_arbiter: round-robin grant, first requester at or after ptr_i scanning upward modulo N.
//   req_i      request vector
//   ptr_i      scan start channel (expected < N)
//   gnt_o      one-hot grant (zero when nothing requests)
//   gnt_idx_o  index of the granted channel
//   any_gnt_o  a grant was issued
module rr_arbiter
    import mux_arb_nx1_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_gnt_o
);
    always_comb begin
        int c;
        c         = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr_i) + i;
            if (c >= N) c = c - N;
            if (!any_gnt_o && req_i[c]) begin
                gnt_o[c]  = 1'b1;
                gnt_idx_o = IW'(c);
                any_gnt_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_arb_nx1.sv
// mux_arb_nx1: N-to-1 valid/ready mux with a registered output stage, select-driven or round-robin.
//   Clock, Reset      clock and synchronous active-low reset
//   hyrja             packed channel data, channel k at [k*WIDTH +: WIDTH]
//   hyrja_valid/ready per-channel handshake; ready is one-hot or zero
//   Sel               channel select (MODE_SEL only)
//   Dalja, dalja_idx  registered output word and the channel it came from
//   dalja_valid/ready output handshake
module mux_arb_nx1
    import mux_arb_nx1_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_SEL,
    localparam int IW    = idx_width(N)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N*WIDTH-1:0]   hyrja,
    input  logic [N-1:0]         hyrja_valid,
    output logic [N-1:0]         hyrja_ready,
    input  logic [IW-1:0]        Sel,
    output logic [WIDTH-1:0]     Dalja,
    output logic                 dalja_valid,
    input  logic                 dalja_ready,
    output logic [IW-1:0]        dalja_idx
);
    logic             load_en, in_xfer, any_gnt, valid_q, valid_d;
    logic [N-1:0]     gnt;
    logic [IW-1:0]    gnt_idx, idx_q;
    logic [WIDTH-1:0] dalja_d, dalja_q;
    logic [15:0]      xfer_cnt_q;
    logic             unused_cnt;

    assign load_en = !valid_q || dalja_ready;

    if (MODE == MODE_RR) begin : g_rr
        logic [IW-1:0] rr_ptr_q, rr_ptr_d;
        logic          unused_sel;
        assign unused_sel = ^Sel;
        rr_arbiter #(.N(N), .IW(IW)) u_arb (
            .req_i    (hyrja_valid),
            .ptr_i    (rr_ptr_q),
            .gnt_o    (gnt),
            .gnt_idx_o(gnt_idx),
            .any_gnt_o(any_gnt)
        );
        assign rr_ptr_d = !in_xfer ? rr_ptr_q : (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IW'(1);
        always_ff @(posedge Clock) rr_ptr_q <= !Reset ? '0 : rr_ptr_d;
    end else begin : g_sel
        // Select mode offers ready on the chosen channel even if it is not valid.
        assign gnt     = (int'(Sel) < N) ? N'(1) << Sel : '0;
        assign gnt_idx = Sel;
        assign any_gnt = |(gnt & hyrja_valid);
    end

    // Reset gates ready so no channel sees a handshake while the stage is being cleared.
    assign hyrja_ready = gnt & {N{load_en && Reset}};
    assign in_xfer     = any_gnt && load_en && Reset;
    assign valid_d     = in_xfer || (valid_q && !dalja_ready);

    always_comb begin
        dalja_d = '0;
        for (int k = 0; k < N; k++) dalja_d = dalja_d | (hyrja[k*WIDTH +: WIDTH] & {WIDTH{gnt[k]}});
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            valid_q    <= 1'b0;
            dalja_q    <= '0;
            idx_q      <= '0;
            xfer_cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (in_xfer) begin
                dalja_q <= dalja_d;
                idx_q   <= gnt_idx;
            end
            if (valid_q && dalja_ready) xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    // Transfer count is kept for debug probing only.
    assign unused_cnt  = ^xfer_cnt_q;
    assign Dalja       = dalja_q;
    assign dalja_valid = valid_q;
    assign dalja_idx   = (N == 1) ? '0 : idx_q;
endmodule

// File: tb/tb_mux_arb_nx1.sv
// tb_mux_arb_nx1: scoreboard bench for select (N=4, N=3) and round-robin (N=4) configurations.
module tb_mux_arb_nx1;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic [63:0] hy0, hy1;
    logic [47:0] hy2;
    logic [3:0]  hv0, hr0, hv1, hr1;
    logic [2:0]  hv2, hr2;
    logic [1:0]  sel0, sel1, sel2, di0, di1, di2;
    logic [15:0] dd0, dd1, dd2;
    logic        dv0, dv1, dv2, dr0, dr1, dr2;

    mux_arb_nx1 #(.WIDTH(16), .N(4), .MODE(0)) u0 (.Clock(clk), .Reset(rst_n), .hyrja(hy0),
        .hyrja_valid(hv0), .hyrja_ready(hr0), .Sel(sel0), .Dalja(dd0), .dalja_valid(dv0),
        .dalja_ready(dr0), .dalja_idx(di0));
    mux_arb_nx1 #(.WIDTH(16), .N(4), .MODE(1)) u1 (.Clock(clk), .Reset(rst_n), .hyrja(hy1),
        .hyrja_valid(hv1), .hyrja_ready(hr1), .Sel(sel1), .Dalja(dd1), .dalja_valid(dv1),
        .dalja_ready(dr1), .dalja_idx(di1));
    mux_arb_nx1 #(.WIDTH(16), .N(3), .MODE(0)) u2 (.Clock(clk), .Reset(rst_n), .hyrja(hy2),
        .hyrja_valid(hv2), .hyrja_ready(hr2), .Sel(sel2), .Dalja(dd2), .dalja_valid(dv2),
        .dalja_ready(dr2), .dalja_idx(di2));

    int n_cmp = 0, n_err = 0;
    logic [17:0] q0[$], q1[$], q2[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) if (rst_n && dv0 && dr0) begin
        logic [17:0] e;
        n_cmp++;
        if (q0.size() == 0) begin
            n_err++;
            $display("FAIL out0 unexpected idx=%0d data=%h", di0, dd0);
        end else begin
            e = q0.pop_front();
            if ({di0, dd0} !== e) begin
                n_err++;
                $display("FAIL out0 got idx=%0d data=%h want idx=%0d data=%h", di0, dd0, e[17:16], e[15:0]);
            end
        end
    end

    always @(negedge clk) if (rst_n && dv1 && dr1) begin
        logic [17:0] e;
        n_cmp++;
        if (q1.size() == 0) begin
            n_err++;
            $display("FAIL out1 unexpected idx=%0d data=%h", di1, dd1);
        end else begin
            e = q1.pop_front();
            if ({di1, dd1} !== e) begin
                n_err++;
                $display("FAIL out1 got idx=%0d data=%h want idx=%0d data=%h", di1, dd1, e[17:16], e[15:0]);
            end
        end
    end

    always @(negedge clk) if (rst_n && dv2 && dr2) begin
        logic [17:0] e;
        n_cmp++;
        if (q2.size() == 0) begin
            n_err++;
            $display("FAIL out2 unexpected idx=%0d data=%h", di2, dd2);
        end else begin
            e = q2.pop_front();
            if ({di2, dd2} !== e) begin
                n_err++;
                $display("FAIL out2 got idx=%0d data=%h want idx=%0d data=%h", di2, dd2, e[17:16], e[15:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        hy0 = '0; hy1 = '0; hy2 = '0; sel1 = 0;
        hv0 = 4'b1111; sel0 = 2; dr0 = 1;
        hv1 = 4'b1111; dr1 = 1;
        hv2 = 3'b111; sel2 = 0; dr2 = 1;
        // reset with traffic offered: nothing may be granted
        #1;
        chk("rst_ready0", 32'(hr0), 0);
        chk("rst_ready1", 32'(hr1), 0);
        chk("rst_ready2", 32'(hr2), 0);
        step(); step();
        chk("rst_valid0", 32'(dv0), 0);
        chk("rst_data0", 32'(dd0), 0);
        chk("rst_idx0", 32'(di0), 0);
        chk("rst_valid1", 32'(dv1), 0);
        chk("rst_valid2", 32'(dv2), 0);
        hv0 = 0; hv1 = 0; hv2 = 0;
        rst_n = 1;
        step();

        // select mode, channel 2
        sel0 = 2; hy0[32 +: 16] = 16'hBEEF; hv0 = 4'b0100; dr0 = 1;
        q0.push_back({2'd2, 16'hBEEF});
        #1 chk("sel2_ready", 32'(hr0), 32'b0100);
        step();
        chk("sel2_data", 32'(dd0), 32'hBEEF);
        chk("sel2_idx", 32'(di0), 2);
        chk("sel2_valid", 32'(dv0), 1);
        hv0 = 0;
        step();
        chk("sel2_drained", 32'(dv0), 0);

        // select mode, backpressure for three cycles
        sel0 = 1; hy0[16 +: 16] = 16'h1111; hv0 = 4'b0010; dr0 = 0;
        q0.push_back({2'd1, 16'h1111});
        step();
        hy0[16 +: 16] = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", 32'(hr0), 0);
            chk("hold_data", 32'(dd0), 32'h1111);
            chk("hold_valid", 32'(dv0), 1);
            step();
        end
        dr0 = 1;
        q0.push_back({2'd1, 16'h2222});
        #1 chk("release_ready", 32'(hr0), 32'b0010);
        step();
        chk("release_data", 32'(dd0), 32'h2222);
        chk("release_valid", 32'(dv0), 1);
        hv0 = 0;
        step();
        chk("release_drained", 32'(dv0), 0);

        // round robin, all channels valid: 0,1,2,3,0,1
        hy1 = {16'hA003, 16'hA002, 16'hA001, 16'hA000}; hv1 = 4'b1111; dr1 = 1;
        q1.push_back({2'd0, 16'hA000}); q1.push_back({2'd1, 16'hA001});
        q1.push_back({2'd2, 16'hA002}); q1.push_back({2'd3, 16'hA003});
        q1.push_back({2'd0, 16'hA000}); q1.push_back({2'd1, 16'hA001});
        repeat (6) step();
        hv1 = 0;
        step();

        // round robin from pointer 2 with ch1 and ch3 valid: 3,1,3
        hy1 = {16'hB003, 16'hB002, 16'hB001, 16'hB000}; hv1 = 4'b1010;
        q1.push_back({2'd3, 16'hB003}); q1.push_back({2'd1, 16'hB001}); q1.push_back({2'd3, 16'hB003});
        repeat (3) step();
        hv1 = 0;
        step();

        // reset while holding a word: word discarded, pointer back to 0
        hy1 = {16'hA003, 16'hA002, 16'hA001, 16'hA000}; hv1 = 4'b0100; dr1 = 0;
        step();
        hv1 = 0;
        step();
        chk("pre_rst_data", 32'(dd1), 32'hA002);
        chk("pre_rst_ready", 32'(hr1), 0);
        rst_n = 0; hv1 = 4'b0100; dr1 = 1;
        #1 chk("midrst_ready", 32'(hr1), 0);
        step();
        chk("midrst_valid", 32'(dv1), 0);
        chk("midrst_data", 32'(dd1), 0);
        chk("midrst_idx", 32'(di1), 0);
        rst_n = 1; hv1 = 4'b1111;
        q1.push_back({2'd0, 16'hA000});
        #1 chk("post_rst_ready", 32'(hr1), 32'b0001);
        step();
        chk("post_rst_idx", 32'(di1), 0);
        hv1 = 0;
        step();

        // N=3 select out of range grants nothing
        hy2 = {16'h3332, 16'h3331, 16'h3330}; hv2 = 3'b111; sel2 = 3; dr2 = 1;
        #1 chk("oor_ready", 32'(hr2), 0);
        step();
        chk("oor_valid_a", 32'(dv2), 0);
        step();
        chk("oor_valid_b", 32'(dv2), 0);
        sel2 = 0;
        q2.push_back({2'd0, 16'h3330});
        #1 chk("n3_ready", 32'(hr2), 32'b001);
        step();
        chk("n3_data", 32'(dd2), 32'h3330);
        hv2 = 0;
        step();

        repeat (3) step();
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        chk("q2_drained", 32'(q2.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
